pearson_hash_core: RTL and testbench
====================================

PEARSON_HASH_CORE -- requirements
Module: pearson_hash_core

Interface
REQ-001 SHALL have parameter DIGEST_BYTES, default 16, number of parallel 8-bit Pearson lanes (legal 1..32); digest width = 8*DIGEST_BYTES.
REQ-002 SHALL have parameter LEN_W, default 16, width of the message byte counter (legal 8..32).
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port s_valid  in  1  input byte valid.
REQ-006 SHALL have port s_ready  out  1  core accepts input byte.
REQ-007 SHALL have port s_data  in  8  message byte.
REQ-008 SHALL have port s_last  in  1  marks the final byte of a message.
REQ-009 SHALL have port m_valid  out  1  digest valid.
REQ-010 SHALL have port m_ready  in  1  downstream accepts digest.
REQ-011 SHALL have port m_digest  out  8*DIGEST_BYTES  digest, lane 0 in bits [7:0].
REQ-012 SHALL have port m_len  out  LEN_W  byte count of the digested message.

Function
REQ-013 SHALL use table T[i] = (167*i + 13) mod 256, i = 0..255, as a ROM bijection; each lane holds its own copy so all lanes advance in one cycle.
REQ-014 SHALL accept a byte only when s_valid && s_ready are both high at a rising edge (beat).
REQ-015 SHALL compute, per lane j on the first beat of a message, h_j = T[(s_data + j) mod 256]; on each later beat, h_j = T[h_j XOR s_data].
REQ-016 SHALL implement FSM IDLE -> ACCUM on a first beat with s_last=0, IDLE -> DONE on a first beat with s_last=1, ACCUM -> DONE on a beat with s_last=1, and DONE -> IDLE when m_valid && m_ready.
REQ-017 SHALL drive s_ready=1 in IDLE and ACCUM and s_ready=0 in DONE; s_ready SHALL not depend combinationally on s_valid.
REQ-018 SHALL drive m_valid=1 only in DONE, asserted the cycle after the last beat (latency 1), with m_digest and m_len stable until the handshake.
REQ-019 SHALL count beats into m_len, loading 1 on a first beat and saturating at 2^LEN_W-1 without wrapping.
REQ-020 SHALL ignore s_data/s_last while s_valid=0 and hold lane state; gaps between beats SHALL not alter the digest.
REQ-021 SHALL allow a new message's first beat in the cycle after the DONE handshake (one IDLE cycle minimum); no empty messages are defined.
REQ-022 SHALL keep s_data/s_last unsampled in DONE so that upstream data is held until s_ready returns.

Reset
REQ-023 SHALL on ARESET=1 force FSM=IDLE, s_ready=0 during the reset cycle and 1 after, m_valid=0, m_digest=0, m_len=0.
REQ-024 SHALL, on a reset asserted mid-message or in DONE, discard partial state and pending digest with no output handshake.

Configuration
REQ-025 SHALL with macro PEARSON_SALT_EN defined add port s_salt  in  8, sampled on the first beat only, changing the first step to h_j = T[((s_data + j) mod 256) XOR s_salt].
REQ-026 SHALL without PEARSON_SALT_EN have no s_salt port and behave as salt = 0x00.

Verification
REQ-027 DIGEST_BYTES=2, single beat 0x00 with s_last=1 -> m_valid next cycle, m_digest=0xB40D, m_len=1.
REQ-028 DIGEST_BYTES=2, beats 0x00, 0x01(last) -> m_digest=0x20E1, m_len=2; same bytes with a 3-cycle s_valid gap -> identical result.
REQ-029 Digest held with m_ready=0 for 5 cycles -> m_valid, m_digest and m_len stable, s_ready=0 throughout; m_ready=1 -> IDLE next cycle, s_ready=1.
REQ-030 LEN_W=8, 300-byte message -> m_len=0xFF (saturated); digest matches the reference model.
REQ-031 ARESET pulsed after 3 beats of a message, then single beat 0x00 -> digest lane 0 = 0x0D, m_len=1, no stale output.
REQ-032 PEARSON_SALT_EN defined, DIGEST_BYTES=1, s_salt=0xFF, single beat 0x00 -> m_digest=0x66.

Source files
------------

// File: rtl/pearson_hash_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : pearson_hash_core_if
//  Purpose  : Byte-stream input and digest output bundle for pearson_hash_core.
//             Build macro PEARSON_SALT_EN adds the 8-bit s_salt input.
//  Revision : 1.0 - initial release
// ============================================================================
interface pearson_hash_core_if #(
  parameter int DIGEST_BYTES = 16,
  parameter int LEN_W        = 16
) ();

  // Message byte stream (upstream drives valid/data/last, core drives ready)
  logic                      s_valid;
  logic                      s_ready;
  logic [7:0]                s_data;
  logic                      s_last;
`ifdef PEARSON_SALT_EN
  logic [7:0]                s_salt;
`endif

  // Digest output (core drives valid/digest/len, downstream drives ready)
  logic                      m_valid;
  logic                      m_ready;
  logic [8*DIGEST_BYTES-1:0] m_digest;
  logic [LEN_W-1:0]          m_len;

`ifdef PEARSON_SALT_EN
  modport slave  (input  s_valid, s_data, s_last, s_salt, m_ready,
                  output s_ready, m_valid, m_digest, m_len);
  modport master (output s_valid, s_data, s_last, s_salt, m_ready,
                  input  s_ready, m_valid, m_digest, m_len);
`else
  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_digest, m_len);
  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_digest, m_len);
`endif

endinterface : pearson_hash_core_if
`default_nettype wire

// File: rtl/pearson_hash_core.sv
`default_nettype none
// ============================================================================
//  Module   : pearson_hash_core
//  Purpose  : Multi-lane 8-bit Pearson hash. Each lane j starts from
//             T[(first byte + j) ^ salt] and then folds every further byte in
//             as h = T[h ^ byte]. T[i] = (167*i + 13) mod 256.
//             Build macro PEARSON_SALT_EN enables the s_salt input; without it
//             the salt is fixed at 0x00.
//  Revision : 1.0 - initial release
// ============================================================================
module pearson_hash_core #(
  parameter int DIGEST_BYTES = 16,
  parameter int LEN_W        = 16
) (
  input  wire logic          ACLK,
  input  wire logic          ARESET,
  pearson_hash_core_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] C_LEN_MAX = {LEN_W{1'b1}};

  // Permutation ROM: 167 is odd, so the affine map is a bijection on 0..255.
  function automatic logic [7:0] t_rom(input logic [7:0] idx);
    logic [15:0] prod;
    prod = 16'(idx) * 16'd167 + 16'd13;
    return prod[7:0];
  endfunction

  state_t           state_q;
  logic             rdy_q;
  logic             mvalid_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       h_q [DIGEST_BYTES];
  logic [7:0]       w_salt;
  logic             w_beat;
  logic             w_first;
  logic [8*DIGEST_BYTES-1:0] w_digest;

`ifdef PEARSON_SALT_EN
  assign w_salt = bus.s_salt;
`else
  assign w_salt = 8'h00;
`endif

  // rdy_q is low only in DONE, so no byte is ever sampled there.
  assign w_beat  = bus.s_valid & rdy_q;
  assign w_first = (state_q == ST_IDLE);

  // Control FSM: message framing, beat counter and registered handshakes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b1;
      mvalid_q <= 1'b0;
      len_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_beat) begin
            len_q <= C_LEN_ONE;
            if (bus.s_last) begin
              state_q  <= ST_DONE;
              rdy_q    <= 1'b0;
              mvalid_q <= 1'b1;
            end else begin
              state_q  <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (w_beat) begin
            if (len_q != C_LEN_MAX) begin
              len_q <= len_q + C_LEN_ONE;
            end
            if (bus.s_last) begin
              state_q  <= ST_DONE;
              rdy_q    <= 1'b0;
              mvalid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (bus.m_ready) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b1;
            mvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          rdy_q    <= 1'b1;
          mvalid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar j = 0; j < DIGEST_BYTES; j++) begin : g_lane
    logic [7:0] w_first_idx;
    logic [7:0] w_next_idx;
    logic [7:0] h_d;

    assign w_first_idx = (bus.s_data + 8'(j)) ^ w_salt;
    assign w_next_idx  = h_q[j] ^ bus.s_data;
    assign h_d         = w_first ? t_rom(w_first_idx) : t_rom(w_next_idx);

    // Lane state advances only on an accepted beat; gaps leave it untouched.
    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        h_q[j] <= 8'h00;
      end else if (w_beat) begin
        h_q[j] <= h_d;
      end
    end
  end : g_lane

  // Pack lanes into the digest bus, lane 0 in the least significant byte.
  always_comb begin
    w_digest = '0;
    for (int k = 0; k < DIGEST_BYTES; k++) begin
      w_digest[8*k +: 8] = h_q[k];
    end
  end

  // Ready is forced low while reset is held so nothing upstream sees a handshake.
  assign bus.s_ready  = rdy_q & ~ARESET;
  assign bus.m_valid  = mvalid_q;
  assign bus.m_digest = w_digest;
  assign bus.m_len    = len_q;

endmodule : pearson_hash_core
`default_nettype wire

// File: tb/tb_pearson_hash_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pearson_hash_core
//  Purpose  : Self-checking bench for pearson_hash_core with a queue-based
//             reference hash. Honors PEARSON_SALT_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pearson_hash_core;

  localparam int DB = 4;
  localparam int LW = 8;

  logic ACLK = 1'b0;
  logic ARESET;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 ACLK = ~ACLK;

  pearson_hash_core_if #(.DIGEST_BYTES(DB), .LEN_W(LW)) bus ();

  pearson_hash_core #(.DIGEST_BYTES(DB), .LEN_W(LW)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  // Reference table straight from the arithmetic definition.
  function automatic logic [7:0] tref(input int i);
    return 8'((167 * i + 13) % 256);
  endfunction

  // Reference digest of a whole message.
  function automatic logic [8*DB-1:0] model(input logic [7:0] msg[$], input logic [7:0] salt);
    logic [8*DB-1:0] d;
    logic [7:0]      h;
    d = '0;
    for (int j = 0; j < DB; j++) begin
      h = tref(((int'(msg[0]) + j) % 256) ^ int'(salt));
      for (int k = 1; k < msg.size(); k++) h = tref(int'(h ^ msg[k]));
      d[8*j +: 8] = h;
    end
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one message, check the digest, hold it 'hold' cycles, then accept it.
  task automatic send_msg(input logic [7:0] msg[$], input logic [7:0] salt,
                          input int gap_lo, input int gap_hi, input int hold,
                          output logic [8*DB-1:0] got);
    logic [8*DB-1:0] exp_d;
    logic [LW-1:0]   exp_l;
    int              guard;
    for (int i = 0; i < msg.size(); i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        bus.s_last  = 1'($urandom);
        @(posedge ACLK); #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = msg[i];
      bus.s_last  = (i == msg.size() - 1);
`ifdef PEARSON_SALT_EN
      bus.s_salt  = (i == 0) ? salt : 8'($urandom);
`endif
      guard = 0;
      while (!bus.s_ready && guard < 20) begin
        @(posedge ACLK); #1;
        guard++;
      end
      if (guard >= 20) chk("s_ready_timeout", 64'(bus.s_ready), 64'd1);
      @(posedge ACLK); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    exp_d = model(msg, salt);
    exp_l = (msg.size() > 255) ? LW'(255) : LW'(msg.size());
    got   = bus.m_digest;
    chk("m_valid_lat1", 64'(bus.m_valid), 64'd1);
    chk("digest", 64'(bus.m_digest), 64'(exp_d));
    chk("m_len", 64'(bus.m_len), 64'(exp_l));
    chk("s_ready_done", 64'(bus.s_ready), 64'd0);
    repeat (hold) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'($urandom);
      bus.s_last  = 1'($urandom);
      @(posedge ACLK); #1;
      chk("hold_valid", 64'(bus.m_valid), 64'd1);
      chk("hold_digest", 64'(bus.m_digest), 64'(exp_d));
      chk("hold_len", 64'(bus.m_len), 64'(exp_l));
      chk("hold_s_ready", 64'(bus.s_ready), 64'd0);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge ACLK); #1;
    bus.m_ready = 1'b0;
    chk("m_valid_drop", 64'(bus.m_valid), 64'd0);
    chk("s_ready_back", 64'(bus.s_ready), 64'd1);
  endtask

  // Hard stop if the run ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]      msg[$];
    logic [8*DB-1:0] got;
    logic [7:0]      salt;
    int              len;

    ARESET      = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
`ifdef PEARSON_SALT_EN
    bus.s_salt  = 8'h00;
`endif
    @(posedge ACLK); #1;
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_digest", 64'(bus.m_digest), 64'd0);
    chk("rst_len", 64'(bus.m_len), 64'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("post_rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("post_rst_m_valid", 64'(bus.m_valid), 64'd0);

    // Single byte 0x00.
    msg = '{8'h00};
    send_msg(msg, 8'h00, 0, 0, 0, got);
    chk("single_00_lo16", 64'(got[15:0]), 64'h B40D);

    // Two bytes back-to-back, held 5 cycles before acceptance.
    msg = '{8'h00, 8'h01};
    send_msg(msg, 8'h00, 0, 0, 5, got);
    chk("two_byte_lo16", 64'(got[15:0]), 64'h20E1);

    // Same bytes with 3-cycle gaps of noise on s_data/s_last.
    send_msg(msg, 8'h00, 3, 3, 0, got);
    chk("two_byte_gap_lo16", 64'(got[15:0]), 64'h20E1);

    // Long message: byte counter saturates.
    msg = {};
    for (int i = 0; i < 300; i++) msg.push_back(8'($urandom));
    send_msg(msg, 8'h00, 0, 1, 1, got);

    // Reset in the middle of a message.
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'($urandom);
      bus.s_last  = 1'b0;
      @(posedge ACLK); #1;
    end
    bus.s_valid = 1'b0;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("midmsg_rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("midmsg_rst_len", 64'(bus.m_len), 64'd0);
    chk("midmsg_rst_digest", 64'(bus.m_digest), 64'd0);
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    chk("midmsg_no_valid", 64'(bus.m_valid), 64'd0);
    msg = '{8'h00};
    send_msg(msg, 8'h00, 0, 0, 0, got);
    chk("after_rst_lane0", 64'(got[7:0]), 64'h0D);

    // Reset while a digest is pending.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    bus.s_last  = 1'b1;
    @(posedge ACLK); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("done_before_rst", 64'(bus.m_valid), 64'd1);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    chk("done_rst_m_valid", 64'(bus.m_valid), 64'd0);
    @(posedge ACLK); #1;
    chk("done_rst_stays_idle", 64'(bus.m_valid), 64'd0);

`ifdef PEARSON_SALT_EN
    msg = '{8'h00};
    send_msg(msg, 8'hFF, 0, 0, 0, got);
    chk("salt_ff_lane0", 64'(got[7:0]), 64'h66);
`endif

    // Randomized messages with random gaps and downstream back-pressure.
    repeat (12) begin
      len = $urandom_range(24, 1);
      msg = {};
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
`ifdef PEARSON_SALT_EN
      salt = 8'($urandom);
`else
      salt = 8'h00;
`endif
      send_msg(msg, salt, 0, 2, $urandom_range(3, 0), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_pearson_hash_core
`default_nettype wire
